// File: rtl/float_to_int_if.sv
// Handshake bundle for float_to_int: float operand in, signed integer out.
// Both sides use stb/ack; a word moves on a rising edge with stb & ack high.
interface float_to_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_ovf;
    logic        output_z_stb;
    logic        output_z_ack;

    // Producer of operands and consumer of results.
    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_ovf, output_z_stb
    );

    // The converter itself.
    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_ovf, output_z_stb
    );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single precision to signed 32-bit integer converter.
// Five-state FSM; one conversion per 6 cycles at best.
// Rounding is truncate (ROUND_MODE=0) or nearest-even (ROUND_MODE=1).
// Overflow either saturates by sign (SATURATE=1) or yields 0x80000000.
module float_to_int #(
    parameter int ROUND_MODE = 0,
    parameter int SATURATE   = 1
) (
    input  logic          clk,
    input  logic          rst,
    float_to_int_if.slave bus
);

    typedef enum logic [2:0] {GET_A, UNPACK, CONVERT, ROUND, PUT_Z} state_t;

    state_t      state_q, state_d;
    logic        a_ack_q, a_ack_d;
    logic [31:0] a_q, a_d;
    logic        special_q, special_d;
    logic [31:0] spec_z_q, spec_z_d;
    logic        spec_ovf_q, spec_ovf_d;
    logic [31:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [31:0] z_q, z_d;
    logic        ovf_q, ovf_d;
    logic        z_stb_q, z_stb_d;

    // Field views of the latched operand. The unbiased exponent
    // e = exp - 127 is never stored: every test on e is written as the
    // equivalent test on the raw exp byte (e = 23 <=> exp = 150, etc.).
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [23:0] m;
    logic [31:0] ovf_val;
    logic [47:0] right_shifted;
    logic [31:0] left_shifted;
    logic        round_inc;
    logic [31:0] rounded;
    logic [31:0] result;

    assign sign = a_q[31];
    assign exp  = a_q[30:23];
    assign mant = a_q[22:0];
    assign m    = {1'b1, mant};

    assign ovf_val = (SATURATE != 0 && !sign) ? 32'h7FFF_FFFF : 32'h8000_0000;

    // Right shift for 0 <= e < 23: the upper 24 bits are the integer
    // magnitude, bit 23 is the guard bit and bits 22:0 feed the sticky OR.
    assign right_shifted = {m, 24'h0} >> (8'd150 - exp);
    // Left shift for e >= 23; only e <= 30 reaches here, so 31 bits suffice.
    assign left_shifted  = {8'h0, m} << (exp - 8'd150);

    assign round_inc = (ROUND_MODE != 0) && guard_q && (sticky_q || mag_q[0]);
    assign rounded   = mag_q + {31'h0, round_inc};
    assign result    = sign ? -rounded : rounded;

    assign bus.input_a_ack  = a_ack_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_ovf = ovf_q;
    assign bus.output_z_stb = z_stb_q;

    // State and datapath registers; reset returns to an idle GET_A with all outputs low.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the datapath registers are few and are reset too, so no X ever
    // reaches the outputs or the classification logic after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GET_A;
            a_ack_q    <= 1'b0;
            a_q        <= '0;
            special_q  <= 1'b0;
            spec_z_q   <= '0;
            spec_ovf_q <= 1'b0;
            mag_q      <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            z_q        <= '0;
            ovf_q      <= 1'b0;
            z_stb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_ack_q    <= a_ack_d;
            a_q        <= a_d;
            special_q  <= special_d;
            spec_z_q   <= spec_z_d;
            spec_ovf_q <= spec_ovf_d;
            mag_q      <= mag_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            z_q        <= z_d;
            ovf_q      <= ovf_d;
            z_stb_q    <= z_stb_d;
        end
    end

    // Next-state and next-datapath logic for the conversion sequence.
    // NOTE: every _d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        a_ack_d    = a_ack_q;
        a_d        = a_q;
        special_d  = special_q;
        spec_z_d   = spec_z_q;
        spec_ovf_d = spec_ovf_q;
        mag_d      = mag_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        z_d        = z_q;
        ovf_d      = ovf_q;
        z_stb_d    = z_stb_q;

        case (state_q)
            GET_A: begin
                if (a_ack_q && bus.input_a_stb) begin
                    a_d     = bus.input_a;
                    a_ack_d = 1'b0;
                    state_d = UNPACK;
                end else begin
                    a_ack_d = 1'b1;
                end
            end

            UNPACK: begin
                special_d  = 1'b0;
                spec_z_d   = 32'h0;
                spec_ovf_d = 1'b0;
                if (exp == 8'd0) begin
                    // Zero or denormal: magnitude below 1, result 0 for either sign.
                    special_d = 1'b1;
                end else if (exp == 8'd255 && mant != 23'h0) begin
                    special_d  = 1'b1;
                    spec_z_d   = 32'h8000_0000;
                    spec_ovf_d = 1'b1;
                end else if (exp > 8'd157) begin
                    // e > 30 (Inf included); only -2^31 exactly is representable.
                    special_d = 1'b1;
                    if (sign && exp == 8'd158 && mant == 23'h0) begin
                        spec_z_d = 32'h8000_0000;
                    end else begin
                        spec_z_d   = ovf_val;
                        spec_ovf_d = 1'b1;
                    end
                end
                state_d = CONVERT;
            end

            CONVERT: begin
                if (exp >= 8'd150) begin
                    mag_d    = left_shifted;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                end else if (exp >= 8'd127) begin
                    mag_d    = {8'h0, right_shifted[47:24]};
                    guard_d  = right_shifted[23];
                    sticky_d = |right_shifted[22:0];
                end else begin
                    mag_d    = 32'h0;
                    guard_d  = (exp == 8'd126);
                    sticky_d = (exp < 8'd126) || (mant != 23'h0);
                end
                state_d = ROUND;
            end

            ROUND: begin
                z_d     = special_q ? spec_z_q : result;
                ovf_d   = special_q ? spec_ovf_q : 1'b0;
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end

            PUT_Z: begin
                if (bus.output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end

            default: state_d = GET_A;
        endcase
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int. Three instances run in lockstep on the
// same stimulus: truncate/saturate, nearest-even/saturate, truncate/wrap.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        a_stb;
    logic        z_ack;
    int          checks   = 0;
    int          failures = 0;

    float_to_int_if if_t ();
    float_to_int_if if_r ();
    float_to_int_if if_w ();

    assign if_t.input_a = a;  assign if_t.input_a_stb = a_stb;  assign if_t.output_z_ack = z_ack;
    assign if_r.input_a = a;  assign if_r.input_a_stb = a_stb;  assign if_r.output_z_ack = z_ack;
    assign if_w.input_a = a;  assign if_w.input_a_stb = a_stb;  assign if_w.output_z_ack = z_ack;

    float_to_int #(.ROUND_MODE(0), .SATURATE(1)) u_trunc (.clk(clk), .rst(rst), .bus(if_t));
    float_to_int #(.ROUND_MODE(1), .SATURATE(1)) u_rne   (.clk(clk), .rst(rst), .bus(if_r));
    float_to_int #(.ROUND_MODE(0), .SATURATE(0)) u_wrap  (.clk(clk), .rst(rst), .bus(if_w));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, expected);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (if_t.input_a_ack !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready", {31'h0, if_t.input_a_ack}, 32'h1);
    endtask

    // One full transaction; expected values for each of the three instances.
    task automatic convert(input logic [31:0] val,
                           input logic [31:0] zt, input logic ot,
                           input logic [31:0] zr, input logic orr,
                           input logic [31:0] zw, input logic ow,
                           input int hold);
        int n = 0;
        wait_ready();
        a = val; a_stb = 1'b1;
        @(posedge clk); #1;
        a_stb = 1'b0; a = 32'hFFFF_FFFF;
        check("ack_drop", {31'h0, if_t.input_a_ack}, 32'h0);
        while (if_t.output_z_stb !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 3);
        check("z_trunc", if_t.output_z, zt);
        check("ovf_trunc", {31'h0, if_t.output_z_ovf}, {31'h0, ot});
        check("z_rne", if_r.output_z, zr);
        check("ovf_rne", {31'h0, if_r.output_z_ovf}, {31'h0, orr});
        check("z_wrap", if_w.output_z, zw);
        check("ovf_wrap", {31'h0, if_w.output_z_ovf}, {31'h0, ow});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_z", if_t.output_z, zt);
            check("hold_stb", {31'h0, if_t.output_z_stb}, 32'h1);
            check("hold_ack", {31'h0, if_t.input_a_ack}, 32'h0);
        end
        z_ack = 1'b1;
        @(posedge clk); #1;
        z_ack = 1'b0;
        check("stb_drop", {31'h0, if_t.output_z_stb}, 32'h0);
        @(posedge clk); #1;
        check("ack_rerise", {31'h0, if_t.input_a_ack}, 32'h1);
    endtask

    initial begin
        int last;
        int nacc;
        int nxf;
        int seen;

        rst = 1'b1; a = 32'h0; a_stb = 1'b0; z_ack = 1'b0;
        #1;
        check("rst_z", if_t.output_z, 32'h0);
        check("rst_stb", {31'h0, if_t.output_z_stb}, 32'h0);
        check("rst_ack", {31'h0, if_t.input_a_ack}, 32'h0);
        check("rst_ovf", {31'h0, if_t.output_z_ovf}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        //       input          trunc             rne               wrap
        convert(32'h41C80000, 32'h00000019, 0, 32'h00000019, 0, 32'h00000019, 0, 0); // 25.0
        convert(32'h40600000, 32'h00000003, 0, 32'h00000004, 0, 32'h00000003, 0, 0); // 3.5
        convert(32'h40200000, 32'h00000002, 0, 32'h00000002, 0, 32'h00000002, 0, 0); // 2.5 tie even
        convert(32'hC0F80000, 32'hFFFFFFF9, 0, 32'hFFFFFFF8, 0, 32'hFFFFFFF9, 0, 0); // -7.75
        convert(32'h3F000000, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0); // 0.5
        convert(32'h3F400000, 32'h00000000, 0, 32'h00000001, 0, 32'h00000000, 0, 0); // 0.75
        convert(32'h3FC00000, 32'h00000001, 0, 32'h00000002, 0, 32'h00000001, 0, 0); // 1.5
        convert(32'h4F32D05E, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 1, 32'h80000000, 1, 0); // ~3e9
        convert(32'hCF000000, 32'h80000000, 0, 32'h80000000, 0, 32'h80000000, 0, 0); // -2^31
        convert(32'h7FC00000, 32'h80000000, 1, 32'h80000000, 1, 32'h80000000, 1, 0); // NaN
        convert(32'h7F800000, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 1, 32'h80000000, 1, 0); // +Inf
        convert(32'hFF800000, 32'h80000000, 1, 32'h80000000, 1, 32'h80000000, 1, 0); // -Inf
        convert(32'h00000001, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0); // denormal
        convert(32'h80000000, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0); // -0
        convert(32'h4EFFFFFF, 32'h7FFFFF80, 0, 32'h7FFFFF80, 0, 32'h7FFFFF80, 0, 0); // e=30
        convert(32'h4B000001, 32'h00800001, 0, 32'h00800001, 0, 32'h00800001, 0, 0); // e=23
        convert(32'h4AFFFFFF, 32'h007FFFFF, 0, 32'h00800000, 0, 32'h007FFFFF, 0, 0); // e=22 tie
        convert(32'h41C80000, 32'h00000019, 0, 32'h00000019, 0, 32'h00000019, 0, 10); // backpressure
        convert(32'hBF800000, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0); // -1.0

        // Streaming with stb and ack held high: one accept every 6 cycles.
        a = 32'h41C80000; a_stb = 1'b1; z_ack = 1'b1;
        last = -1; nacc = 0; nxf = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_t.input_a_ack === 1'b1) begin
                if (last >= 0) check("stream_gap", c - last, 6);
                last = c;
                nacc++;
            end
            if (if_t.output_z_stb === 1'b1) begin
                check("stream_z", if_t.output_z, 32'h19);
                nxf++;
            end
        end
        a_stb = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        z_ack = 1'b0;
        check("stream_accepts", nacc, 7);
        check("stream_results", nxf, 6);

        // Reset during CONVERT: outputs clear at once, aborted operand never appears.
        wait_ready();
        a = 32'h42C80000; a_stb = 1'b1;
        @(posedge clk); #1;
        a_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_z", if_t.output_z, 32'h0);
        check("midrst_stb", {31'h0, if_t.output_z_stb}, 32'h0);
        check("midrst_ack", {31'h0, if_t.input_a_ack}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if_t.output_z_stb !== 1'b0) seen++;
        end
        check("aborted_no_stb", seen, 0);
        convert(32'h40A00000, 32'h00000005, 0, 32'h00000005, 0, 32'h00000005, 0, 0); // 5.0

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
